wb_commit_unit: RTL
===================

# wb_commit_unit

Parametrised multi-port write-back and commit block at the tail of the pipeline. It accepts up to NUM_WB write-back channels per cycle and selects each channel's result. It writes the architectural register file and suppresses duplicate presentations of the same instruction. It also counts retired instructions and serves NUM_RD bypassed read ports to the decode stage.

## Interface
- XLEN, 32, data and address width
- NREG, 32, architectural register count; index width RW = $clog2(NREG)
- IID_W, 8, instruction-id width
- NUM_WB, 2, write-back channels; higher index is younger in program order
- NUM_RD, 2, register read ports
- SP_INIT, 32'h00007500, reset value of x2
- REG_INIT, all-ones (XLEN bits), reset value of x1 and x3..x(NREG-1)
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- wb_valid[NUM_WB]  in  1 each  channel carries an instruction
- wb_pc[NUM_WB]  in  XLEN  instruction PC
- wb_inst_id[NUM_WB]  in  IID_W  instruction id
- wb_sel[NUM_WB]  in  2  0=ALU, 1=MEM, 2=PC+4, 3=CSR
- wb_wen[NUM_WB]  in  1  register write enable
- wb_addr[NUM_WB]  in  RW  destination register
- wb_alu_out / wb_mem_rdata / wb_csr_rdata[NUM_WB]  in  XLEN  result sources
- wb_wdata_out[NUM_WB]  out  XLEN  selected result, combinational, for forwarding
- wb_commit[NUM_WB]  out  1  channel is a new instruction this cycle, combinational
- rd_addr[NUM_RD]  in  RW  read address
- rd_data[NUM_RD]  out  XLEN  read data, bypassed
- inst_count  out  64  retired-instruction counter

## Operation
- Data select per channel:
  - sel 0 → alu_out
  - sel 1 → mem_rdata
  - sel 2 → pc+4 (modulo 2^XLEN)
  - sel 3 → csr_rdata
- Duplicate suppression: per channel, a register pair {seen, last_id}.
  - wb_commit[i] = wb_valid[i] && (!seen[i] || last_id[i] != wb_inst_id[i]).
  - On wb_valid[i]: last_id[i] ← id and seen[i] ← 1, whether or not the instruction was new.
- Register write on posedge when wb_commit[i] && wb_wen[i] && wb_addr[i] != 0.
  - x0 is never written and always reads 0.
- Same-cycle conflict on the same address: the highest-index committing channel wins.
- inst_count += popcount(wb_commit) each cycle. The counter wraps at 2^64.
- Read ports: rd_data[j] = 0 if rd_addr[j] == 0.
  - Otherwise, if any channel is committing a write to rd_addr[j] this cycle, return that channel's wdata; the highest index wins.
  - Otherwise return the register file contents.
- Reset, whenever asserted including mid-stream:
  - x0 = 0, x2 = SP_INIT, all other registers = REG_INIT.
  - seen[] = 0, last_id[] = 0, inst_count = 0.
  - All writes in the reset cycle are discarded.

## Timing
- Write latency: data is in the register file after the posedge following commit.
- Read ports observe a commit combinationally in the same cycle through the bypass.
- wb_wdata_out, wb_commit and rd_data are purely combinational. They carry no state beyond the registers above.
- inst_count reflects commits up to and including the previous cycle.
- Reset values after a reset posedge:
  - inst_count = 0.
  - rd_data = reset register contents; bypass still applies if inputs are committing.
- A channel holding the same id for many cycles (stall) commits exactly once.
- Two channels presenting the same id are independent; the upstream guarantees uniqueness across channels.
- The first valid after reset always commits, even if its id equals 0.

## Test plan
- Reset, then read x0, x1 and x2 → rd_data 0, 0xFFFFFFFF, 0x00007500; inst_count 0.
- Channel 0 commits id 5, sel ALU, addr 3, alu 0x1234, and holds for 4 cycles → single write, x3 = 0x1234, inst_count 1; rd_addr=3 returns 0x1234 in the commit cycle via bypass.
- Both channels write x7 in the same cycle (ch0 0xAAAA, ch1 0xBBBB) → x7 = 0xBBBB, rd bypass 0xBBBB, inst_count += 2.
- sel PC with pc 0xFFFFFFFC writing x1 → x1 = 0x00000000; a write to x0 with value 0x55 → x0 still reads 0, inst_count still incremented.
- Channel 1 commits ids 0, 0, 1, 1, 1, 2 → wb_commit high 3 times; first id 0 after reset commits.
- Assert reset in the cycle channel 0 commits x4 = 0x99 → x4 = 0xFFFFFFFF and inst_count 0 after the edge; the same id presented after reset commits again.

Source files
------------

// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - multi-channel write-back, commit, register file and retire counter
module wb_commit_unit #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter int              IID_W    = 8,
  parameter int              NUM_WB   = 2,
  parameter int              NUM_RD   = 2,
  parameter logic [XLEN-1:0] SP_INIT  = 'h00007500,
  parameter logic [XLEN-1:0] REG_INIT = '1,
  localparam int             RW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_WB-1:0]   wb_valid,
  input  logic [XLEN-1:0]     wb_pc        [NUM_WB],
  input  logic [IID_W-1:0]    wb_inst_id   [NUM_WB],
  input  logic [1:0]          wb_sel       [NUM_WB],
  input  logic [NUM_WB-1:0]   wb_wen,
  input  logic [RW-1:0]       wb_addr      [NUM_WB],
  input  logic [XLEN-1:0]     wb_alu_out   [NUM_WB],
  input  logic [XLEN-1:0]     wb_mem_rdata [NUM_WB],
  input  logic [XLEN-1:0]     wb_csr_rdata [NUM_WB],
  output logic [XLEN-1:0]     wb_wdata_out [NUM_WB],
  output logic [NUM_WB-1:0]   wb_commit,
  input  logic [RW-1:0]       rd_addr      [NUM_RD],
  output logic [XLEN-1:0]     rd_data      [NUM_RD],
  output logic [63:0]         inst_count
);

  logic [XLEN-1:0]  regs_q     [NREG];
  logic [NUM_WB-1:0] seen_q;
  logic [IID_W-1:0] last_id_q  [NUM_WB];
  logic [63:0]      inst_count_q;
  logic [63:0]      inst_count_d;
  logic [NUM_WB-1:0] wr_en;

  // Per-channel result select; PC+4 wraps naturally at XLEN bits.
  always_comb begin
    for (int i = 0; i < NUM_WB; i++) begin
      wb_wdata_out[i] = '0;
      case (wb_sel[i])
        2'd0:    wb_wdata_out[i] = wb_alu_out[i];
        2'd1:    wb_wdata_out[i] = wb_mem_rdata[i];
        2'd2:    wb_wdata_out[i] = wb_pc[i] + XLEN'(4);
        default: wb_wdata_out[i] = wb_csr_rdata[i];
      endcase
    end
  end

  // A channel commits unless it re-presents the id it last carried (stall replay).
  always_comb begin
    wb_commit = '0;
    wr_en     = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      wb_commit[i] = wb_valid[i] && (!seen_q[i] || (last_id_q[i] != wb_inst_id[i]));
      wr_en[i]     = wb_commit[i] && wb_wen[i] && (wb_addr[i] != '0);
    end
  end

  // Retired-instruction count grows by the number of committing channels.
  always_comb begin
    inst_count_d = inst_count_q;
    for (int i = 0; i < NUM_WB; i++) begin
      inst_count_d = inst_count_d + 64'(wb_commit[i]);
    end
  end

  // Bypassed reads: youngest committing writer to the address beats the register file.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_data[j] = regs_q[rd_addr[j]];
      for (int i = 0; i < NUM_WB; i++) begin
        if (wr_en[i] && (wb_addr[i] == rd_addr[j])) begin
          rd_data[j] = wb_wdata_out[i];
        end
      end
      if (rd_addr[j] == '0) begin
        rd_data[j] = '0;
      end
    end
  end

  // Register file; ascending loop lets the younger channel's write land last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)      regs_q[r] <= '0;
        else if (r == 2) regs_q[r] <= SP_INIT;
        else             regs_q[r] <= REG_INIT;
      end
    end else begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wr_en[i]) begin
          regs_q[wb_addr[i]] <= wb_wdata_out[i];
        end
      end
    end
  end

  // Duplicate-tracking state and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q       <= '0;
      inst_count_q <= '0;
      for (int i = 0; i < NUM_WB; i++) begin
        last_id_q[i] <= '0;
      end
    end else begin
      inst_count_q <= inst_count_d;
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i]) begin
          seen_q[i]    <= 1'b1;
          last_id_q[i] <= wb_inst_id[i];
        end
      end
    end
  end

  assign inst_count = inst_count_q;

endmodule
